// File: rtl/writeback_buffer.sv
// -----------------------------------------------------------------------------
// writeback_buffer
//
// Small FIFO that sits between a result producer and the register file write
// port. Results are queued oldest-first and written whenever the write port is
// free (hold low). Writes to register 0 are accepted but dropped, because that
// register is hard-wired to zero. An optional forwarding lookup reports the
// youngest pending value for a queried register.
//
// Parameters
//   DEPTH   number of buffered writes (power of two, >= 2)
//   DATA_W  result data width
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   inValid        producer offers a result
//   inAddress      destination register of the offered result
//   inData         offered result value
//   inReady        buffer can accept this cycle (depends on occupancy only)
//   hold           register file write port busy; nothing drains this cycle
//   writeAddress   head entry address (0 when empty)
//   writeData      head entry data (0 when empty)
//   writeEnable    head entry is written and popped at the next rising edge
//   lookupAddress  forwarding query register
//   lookupHit      a pending write to lookupAddress exists
//   lookupData     data of the youngest pending write to lookupAddress
//   count          number of pending entries
//
// Handshake: a result transfers at a rising edge where inValid && inReady.
// The producer must keep inValid/inAddress/inData stable until that edge.
// inReady never depends on inValid or on a same-cycle drain.
//
// Build option
//   WB_FORWARD_EN  defined: forwarding compare logic is built.
//                  undefined: lookupHit/lookupData are tied to 0.
// -----------------------------------------------------------------------------
module writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inValid,
    input  logic [4:0]                   inAddress,
    input  logic [DATA_W-1:0]            inData,
    output logic                         inReady,
    input  logic                         hold,
    output logic [4:0]                   writeAddress,
    output logic [DATA_W-1:0]            writeData,
    output logic                         writeEnable,
    input  logic [4:0]                   lookupAddress,
    output logic                         lookupHit,
    output logic [DATA_W-1:0]            lookupData,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [4:0]        mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  occupancy;

    logic accept;
    logic push;
    logic pop;
    logic head_valid;

    assign count   = occupancy;
    assign inReady = (occupancy != FULL_COUNT);
    assign accept  = inValid && inReady && !rst;
    // Register 0 writes are consumed here and never enqueued.
    assign push    = accept && (inAddress != 5'd0);

    // Entries are discarded by the reset edge, so the write port is kept
    // quiet while rst is high to avoid committing entries being dropped.
    assign head_valid   = (occupancy != '0) && !rst;
    assign writeEnable  = head_valid && !hold;
    assign pop          = writeEnable;
    assign writeAddress = head_valid ? mem_addr[head] : 5'd0;
    assign writeData    = head_valid ? mem_data[head] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= 5'd0;
                mem_data[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_addr[tail] <= inAddress;
                mem_data[tail] <= inData;
                tail           <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < occupancy) && (mem_addr[idx] == lookupAddress)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[idx];
            end
        end
        if ((lookupAddress == 5'd0) || rst) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

    assign lookupHit  = fwd_hit;
    assign lookupData = fwd_data;
`else
    logic unused_lookup;
    assign unused_lookup = ^lookupAddress;
    assign lookupHit     = 1'b0;
    assign lookupData    = '0;
`endif

endmodule
